his_acq_sequencer: RTL and testbench
====================================

HIS_ACQ_SEQUENCER -- requirements
Module: his_acq_sequencer

Interface
REQ-001 Parameter NP, default 10: TDC sample / peak width in bits.
REQ-002 Parameter PIXEL_NUM, default 6: pixels per histogram builder.
REQ-003 Parameter ACQ_NUM, default 2: acquisitions per frame.
REQ-004 Parameter DRAIN_CYC, default 2: builder pipeline drain cycles before readout.
REQ-005 Ports, clock and reset first:
- clk  in  1  single clock; all logic rising-edge.
- res  in  1  asynchronous, active-high reset.
- start  in  1  frame start pulse.
- abort  in  1  synchronous abort.
- tdc_valid  in  1  sample valid.
- tdc_data  in  NP  TDC sample.
- tdc_ready  out  1  sample accept.
- hb_clr  out  1  builder histogram clear.
- hb_wr_en  out  1  builder write enable.
- hb_data  out  NP  builder write data.
- hb_pix  out  PW  target pixel; PW = max(1, clog2(PIXEL_NUM)).
- hb_rd_addr  out  PW  builder peak read address.
- peak_in  in  NP  builder peak for hb_rd_addr, one-cycle read latency.
- peak_valid  out  1  readout valid.
- peak_data  out  NP  readout peak.
- peak_pix  out  PW  readout pixel index.
- peak_ready  in  1  readout accept.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle frame-complete pulse.

Function
REQ-006 FSM states: IDLE, CLEAR, ACQ, DRAIN, READOUT, DONE.
REQ-007 IDLE -> CLEAR on start; start is ignored in all other states.
REQ-008 CLEAR lasts exactly 1 cycle with hb_clr=1, then ACQ.
REQ-009 tdc_ready=1 only in ACQ; a sample is accepted when tdc_valid&tdc_ready.
REQ-010 Accepted sample n drives hb_wr_en=1, hb_data=sample, hb_pix=n mod PIXEL_NUM on the next cycle (latency 1); hb_wr_en=0 otherwise.
REQ-011 The pixel counter wraps PIXEL_NUM-1 -> 0; the acquisition counter increments on each wrap.
REQ-012 When sample PIXEL_NUM*ACQ_NUM-1 is accepted, tdc_ready drops the next cycle and the FSM enters DRAIN.
REQ-013 DRAIN holds for DRAIN_CYC cycles, then READOUT.
REQ-014 READOUT presents hb_rd_addr 0..PIXEL_NUM-1 and registers peak_in into peak_data/peak_pix with peak_valid=1.
REQ-015 peak_data/peak_pix SHALL stay stable while peak_valid&!peak_ready; hb_rd_addr advances only on a handshake.
REQ-016 After the handshake for pixel PIXEL_NUM-1: DONE for 1 cycle (done=1), then IDLE.
REQ-017 abort in any state: next cycle FSM=IDLE, counters=0, and all strobes/valids=0; abort takes priority over start and handshakes in the same cycle.
REQ-018 Counters never exceed their terminal value; no partial frame is retained after abort.

Reset
REQ-019 res=1 asynchronously forces IDLE, clears counters, and sets every output to 0, including mid-ACQ or mid-READOUT.
REQ-020 After res deasserts, the first frame starts only on a new start pulse.

Configuration
REQ-021 Macro HIS_SEQ_NOHIT_FILTER_EN.
- Defined: a sample equal to all-ones (no-hit code) still consumes a pixel slot and advances the counters, but hb_wr_en stays 0 for it; extra output nohit_cnt (16 bits, saturating, cleared in CLEAR) counts these samples.
- Undefined: every accepted sample is written; nohit_cnt does not exist.

Structure
REQ-022 Package his_seq_pkg holds the state enum, the PW width function, and the no-hit constant.
REQ-023 Readout register/handshake is a sub-module his_seq_rd_stage; the FSM and counters stay in the top level.

Verification
REQ-024 Reset: assert res mid-ACQ -> all outputs 0 immediately; a start 3 cycles later runs a full frame.
REQ-025 Normal frame: 12 samples (108,511,1022,...) with tdc_valid held high -> hb_pix sequence 0..5,0..5; tdc_ready low after the 12th sample; done asserted 1 cycle after the 6th peak handshake.
REQ-026 Backpressure: peak_ready low for 4 cycles on pixel 2 -> peak_data/peak_pix held, hb_rd_addr held at 2, no peak lost.
REQ-027 Gapped input: tdc_valid toggling 1/0 -> hb_wr_en only on accepted cycles, pixel order unchanged.
REQ-028 Abort during DRAIN, and abort coincident with start in IDLE -> IDLE next cycle, no hb_wr_en or peak_valid.
REQ-029 With HIS_SEQ_NOHIT_FILTER_EN: samples of 1023 at pixels 1 and 4 -> no writes for those pixels, nohit_cnt=2, frame still ends after 12 samples.

Source files
------------

// File: rtl/his_seq_pkg.sv
// Shared types and helpers for the histogram acquisition sequencer.
package his_seq_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      ACQ     = 3'd2,
      DRAIN   = 3'd3,
      READOUT = 3'd4,
      DONE    = 3'd5
   } seqState_t;

   // Counter width for n distinct values; never narrower than one bit.
   function automatic int pixWidth(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // TDC code meaning "no hit": all ones at the sample width.
   function automatic logic [31:0] noHitCode(input int np);
      return (np >= 32) ? 32'hFFFF_FFFF : ((32'd1 << np) - 32'd1);
   endfunction

endpackage

// File: rtl/his_seq_rd_stage.sv
// Peak readout stage: issues one builder read, registers the returned peak
// and holds it until the consumer accepts it.
module his_seq_rd_stage #(
   parameter int NP = 10,
   parameter int PW = 3
) (
   input  logic          clk,
   input  logic          res,
   input  logic          clr,
   input  logic          active,
   input  logic [PW-1:0] rdAddr,
   input  logic [NP-1:0] peakIn,
   input  logic          peakReady,
   output logic          peakValid,
   output logic [NP-1:0] peakData,
   output logic [PW-1:0] peakPix,
   output logic          hsk
);

   logic          pend;
   logic          validQ;
   logic [NP-1:0] dataQ;
   logic [PW-1:0] pixQ;
   logic          fetch;

   // A new read goes out only when nothing is in flight or waiting for accept.
   assign fetch = active && !pend && !validQ;
   assign hsk   = validQ && peakReady;

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         pend   <= 1'b0;
         validQ <= 1'b0;
         dataQ  <= '0;
         pixQ   <= '0;
      end else if (clr) begin
         pend   <= 1'b0;
         validQ <= 1'b0;
         dataQ  <= '0;
         pixQ   <= '0;
      end else begin
         pend <= fetch;
         if (pend) begin
            validQ <= 1'b1;
            dataQ  <= peakIn;
            pixQ   <= rdAddr;
         end else if (hsk) begin
            validQ <= 1'b0;
         end
      end
   end

   assign peakValid = validQ;
   assign peakData  = dataQ;
   assign peakPix   = pixQ;

endmodule

// File: rtl/his_acq_sequencer.sv
// Frame sequencer for a histogram builder: clear, acquire, drain, read out peaks.
// Define HIS_SEQ_NOHIT_FILTER_EN to drop all-ones samples and count them on nohit_cnt.
//   state   | meaning
//   IDLE    | waiting for start
//   CLEAR   | one-cycle histogram clear
//   ACQ     | accepting TDC samples, pixel round-robin
//   DRAIN   | letting the builder pipeline settle
//   READOUT | streaming one peak per pixel
//   DONE    | one-cycle frame-complete pulse
module his_acq_sequencer
   import his_seq_pkg::*;
#(
   parameter  int NP        = 10,
   parameter  int PIXEL_NUM = 6,
   parameter  int ACQ_NUM   = 2,
   parameter  int DRAIN_CYC = 2,
   localparam int PW        = pixWidth(PIXEL_NUM)
) (
   input  logic          clk,
   input  logic          res,
   input  logic          start,
   input  logic          abort,
   input  logic          tdc_valid,
   input  logic [NP-1:0] tdc_data,
   output logic          tdc_ready,
   output logic          hb_clr,
   output logic          hb_wr_en,
   output logic [NP-1:0] hb_data,
   output logic [PW-1:0] hb_pix,
   output logic [PW-1:0] hb_rd_addr,
   input  logic [NP-1:0] peak_in,
   output logic          peak_valid,
   output logic [NP-1:0] peak_data,
   output logic [PW-1:0] peak_pix,
   input  logic          peak_ready,
   output logic          busy,
   output logic          done
`ifdef HIS_SEQ_NOHIT_FILTER_EN
   ,
   output logic [15:0]   nohit_cnt
`endif
);

   localparam int AW = pixWidth(ACQ_NUM);
   localparam int DW = pixWidth(DRAIN_CYC);
   localparam logic [PW-1:0] PIX_LAST   = PW'(PIXEL_NUM - 1);
   localparam logic [AW-1:0] ACQ_LAST   = AW'(ACQ_NUM - 1);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYC - 1);

   seqState_t     state;
   seqState_t     stateNxt;
   logic [PW-1:0] pixCnt;
   logic [AW-1:0] acqCnt;
   logic [DW-1:0] drainCnt;
   logic [PW-1:0] rdAddr;
   logic          accept;
   logic          lastSample;
   logic          isNoHit;
   logic          rdHsk;
   logic          lastPeak;
   logic          wrEnQ;
   logic [NP-1:0] wrDataQ;
   logic [PW-1:0] wrPixQ;
   logic          tdcReadyC;
   logic          hbClrC;
   logic          busyC;
   logic          doneC;

   assign accept     = tdcReadyC && tdc_valid;
   assign lastSample = (pixCnt == PIX_LAST) && (acqCnt == ACQ_LAST);
   assign lastPeak   = rdHsk && (rdAddr == PIX_LAST);

   always_ff @(posedge clk or posedge res) begin
      if (res) state <= IDLE;
      else     state <= stateNxt;
   end

   always_comb begin
      stateNxt = state;
      if (abort) begin
         stateNxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start) stateNxt = CLEAR;
            CLEAR:   stateNxt = ACQ;
            ACQ:     if (accept && lastSample) stateNxt = DRAIN;
            DRAIN:   if (drainCnt == '0) stateNxt = READOUT;
            READOUT: if (lastPeak) stateNxt = DONE;
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
         endcase
      end
   end

   always_comb begin
      tdcReadyC = 1'b0;
      hbClrC    = 1'b0;
      busyC     = 1'b1;
      doneC     = 1'b0;
      case (state)
         IDLE:    busyC     = 1'b0;
         CLEAR:   hbClrC    = 1'b1;
         ACQ:     tdcReadyC = 1'b1;
         DONE:    doneC     = 1'b1;
         default: ;
      endcase
   end

   // Pixel / acquisition counters; both wrap so they never pass their terminal value.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         pixCnt <= '0;
         acqCnt <= '0;
      end else if (abort || state == CLEAR) begin
         pixCnt <= '0;
         acqCnt <= '0;
      end else if (accept) begin
         if (pixCnt == PIX_LAST) begin
            pixCnt <= '0;
            acqCnt <= (acqCnt == ACQ_LAST) ? '0 : acqCnt + AW'(1);
         end else begin
            pixCnt <= pixCnt + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         drainCnt <= '0;
      end else if (abort) begin
         drainCnt <= '0;
      end else if (accept && lastSample) begin
         drainCnt <= DRAIN_LOAD;
      end else if (state == DRAIN && drainCnt != '0) begin
         drainCnt <= drainCnt - DW'(1);
      end
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         rdAddr <= '0;
      end else if (abort || state != READOUT) begin
         rdAddr <= '0;
      end else if (rdHsk) begin
         rdAddr <= (rdAddr == PIX_LAST) ? '0 : rdAddr + PW'(1);
      end
   end

   // One-cycle write latency toward the builder.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         wrEnQ   <= 1'b0;
         wrDataQ <= '0;
         wrPixQ  <= '0;
      end else if (abort) begin
         wrEnQ   <= 1'b0;
         wrDataQ <= '0;
         wrPixQ  <= '0;
      end else begin
         wrEnQ <= accept && !isNoHit;
         if (accept) begin
            wrDataQ <= tdc_data;
            wrPixQ  <= pixCnt;
         end
      end
   end

`ifdef HIS_SEQ_NOHIT_FILTER_EN
   localparam logic [NP-1:0] NOHIT = NP'(noHitCode(NP));
   logic [15:0] nohitCnt;

   assign isNoHit = (tdc_data == NOHIT);

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         nohitCnt <= '0;
      end else if (abort || state == CLEAR) begin
         nohitCnt <= '0;
      end else if (accept && isNoHit && nohitCnt != 16'hFFFF) begin
         nohitCnt <= nohitCnt + 16'd1;
      end
   end

   assign nohit_cnt = nohitCnt;
`else
   assign isNoHit = 1'b0;
`endif

   his_seq_rd_stage #(
      .NP (NP),
      .PW (PW)
   ) u_rd_stage (
      .clk       (clk),
      .res       (res),
      .clr       (abort),
      .active    (state == READOUT),
      .rdAddr    (rdAddr),
      .peakIn    (peak_in),
      .peakReady (peak_ready),
      .peakValid (peak_valid),
      .peakData  (peak_data),
      .peakPix   (peak_pix),
      .hsk       (rdHsk)
   );

   assign tdc_ready  = tdcReadyC;
   assign hb_clr     = hbClrC;
   assign hb_wr_en   = wrEnQ;
   assign hb_data    = wrDataQ;
   assign hb_pix     = wrPixQ;
   assign hb_rd_addr = rdAddr;
   assign busy       = busyC;
   assign done       = doneC;

endmodule

// File: tb/tb_his_acq_sequencer.sv
// Directed bench for his_acq_sequencer; writes and peaks are checked against queued expectations.
module tb_his_acq_sequencer;

   localparam int NP    = 10;
   localparam int PIXN  = 6;
   localparam int ACQN  = 2;
   localparam int PW    = 3;
   localparam int NSAMP = PIXN * ACQN;
   localparam logic [NP-1:0] NOHIT = 10'h3FF;
`ifdef HIS_SEQ_NOHIT_FILTER_EN
   localparam bit FILT = 1'b1;
   logic [15:0] nohit_cnt;
`else
   localparam bit FILT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          res = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          tdc_valid = 1'b0;
   logic [NP-1:0] tdc_data = '0;
   logic          tdc_ready;
   logic          hb_clr;
   logic          hb_wr_en;
   logic [NP-1:0] hb_data;
   logic [PW-1:0] hb_pix;
   logic [PW-1:0] hb_rd_addr;
   logic [NP-1:0] peak_in = '0;
   logic          peak_valid;
   logic [NP-1:0] peak_data;
   logic [PW-1:0] peak_pix;
   logic          peak_ready = 1'b1;
   logic          busy;
   logic          done;

   int total = 0;
   int bad   = 0;
   logic [PW+NP-1:0] wq[$];
   logic [PW+NP-1:0] pq[$];
   logic [NP-1:0]    peakMem [PIXN];
   logic [NP-1:0]    samp [NSAMP];
   logic             hskLastQ = 1'b0;

   his_acq_sequencer #(
      .NP        (NP),
      .PIXEL_NUM (PIXN),
      .ACQ_NUM   (ACQN),
      .DRAIN_CYC (2)
   ) dut (
      .clk        (clk),
      .res        (res),
      .start      (start),
      .abort      (abort),
      .tdc_valid  (tdc_valid),
      .tdc_data   (tdc_data),
      .tdc_ready  (tdc_ready),
      .hb_clr     (hb_clr),
      .hb_wr_en   (hb_wr_en),
      .hb_data    (hb_data),
      .hb_pix     (hb_pix),
      .hb_rd_addr (hb_rd_addr),
      .peak_in    (peak_in),
      .peak_valid (peak_valid),
      .peak_data  (peak_data),
      .peak_pix   (peak_pix),
      .peak_ready (peak_ready),
      .busy       (busy),
      .done       (done)
`ifdef HIS_SEQ_NOHIT_FILTER_EN
      ,
      .nohit_cnt  (nohit_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Builder model: registered peak memory, one-cycle read latency.
   always @(posedge clk) peak_in <= peakMem[int'(hb_rd_addr)];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      logic [PW+NP-1:0] e;
      if (hb_wr_en === 1'b1) begin
         if (wq.size() == 0) chk("wr_unexpected", 32'(hb_wr_en), 0);
         else begin
            e = wq.pop_front();
            chk("wr_pix", 32'(hb_pix), 32'(e[PW+NP-1:NP]));
            chk("wr_data", 32'(hb_data), 32'(e[NP-1:0]));
         end
      end
      if (peak_valid === 1'b1 && peak_ready === 1'b1) begin
         if (pq.size() == 0) chk("peak_unexpected", 32'(peak_valid), 0);
         else begin
            e = pq.pop_front();
            chk("peak_pix", 32'(peak_pix), 32'(e[PW+NP-1:NP]));
            chk("peak_data", 32'(peak_data), 32'(e[NP-1:0]));
         end
      end
      if (done === 1'b1) chk("done_after_last_hsk", 32'(hskLastQ), 1);
      hskLastQ = (peak_valid === 1'b1) && (peak_ready === 1'b1) && (peak_pix == PW'(PIXN - 1));
   end

   task automatic chkAllZero(input string pre);
      chk({pre, "_tdc_ready"}, 32'(tdc_ready), 0);
      chk({pre, "_hb_clr"}, 32'(hb_clr), 0);
      chk({pre, "_hb_wr_en"}, 32'(hb_wr_en), 0);
      chk({pre, "_hb_data"}, 32'(hb_data), 0);
      chk({pre, "_hb_pix"}, 32'(hb_pix), 0);
      chk({pre, "_hb_rd_addr"}, 32'(hb_rd_addr), 0);
      chk({pre, "_peak_valid"}, 32'(peak_valid), 0);
      chk({pre, "_peak_data"}, 32'(peak_data), 0);
      chk({pre, "_peak_pix"}, 32'(peak_pix), 0);
      chk({pre, "_busy"}, 32'(busy), 0);
      chk({pre, "_done"}, 32'(done), 0);
   endtask

   task automatic startFrame(input int fr);
      for (int p = 0; p < PIXN; p++) peakMem[p] = NP'(37 * p + 101 * fr + 9);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("clear_pulse", 32'(hb_clr), 1);
      chk("clear_busy", 32'(busy), 1);
      chk("clear_no_ready", 32'(tdc_ready), 0);
      cyc();
      chk("acq_clr_low", 32'(hb_clr), 0);
   endtask

   task automatic feed(input bit gapped, input bit pushPeaks);
      for (int i = 0; i < NSAMP; i++) begin
         chk("acq_ready", 32'(tdc_ready), 1);
         tdc_valid = 1'b1;
         tdc_data  = samp[i];
         if (!(FILT && samp[i] == NOHIT)) wq.push_back({PW'(i % PIXN), samp[i]});
         cyc();
         if (gapped && i < NSAMP - 1) begin
            tdc_valid = 1'b0;
            tdc_data  = ~samp[i];
            cyc();
         end
      end
      if (pushPeaks) for (int p = 0; p < PIXN; p++) pq.push_back({PW'(p), peakMem[p]});
      chk("ready_low_after_last", 32'(tdc_ready), 0);
      cyc();
      chk("drain_no_ready", 32'(tdc_ready), 0);
      tdc_valid = 1'b0;
   endtask

   task automatic readout(input int stallPix);
      int budget = 0;
      bit stalled = 1'b0;
      chk("drain_no_peak", 32'(peak_valid), 0);
      while (done !== 1'b1 && budget < 200) begin
         if (stallPix >= 0 && !stalled && peak_valid === 1'b1 && int'(peak_pix) == stallPix) begin
            peak_ready = 1'b0;
            stalled    = 1'b1;
            for (int k = 0; k < 4; k++) begin
               cyc();
               chk("stall_valid", 32'(peak_valid), 1);
               chk("stall_data", 32'(peak_data), 32'(peakMem[stallPix]));
               chk("stall_pix", 32'(peak_pix), 32'(stallPix));
               chk("stall_addr", 32'(hb_rd_addr), 32'(stallPix));
            end
            peak_ready = 1'b1;
         end
         cyc();
         budget++;
      end
      chk("frame_done", 32'(done), 1);
      chk("peaks_all_out", 32'(pq.size()), 0);
      chk("writes_all_out", 32'(wq.size()), 0);
      cyc();
      chk("done_one_cycle", 32'(done), 0);
      chk("idle_after_done", 32'(busy), 0);
   endtask

   initial begin
      samp = '{10'd108, 10'd511, 10'd1022, 10'd0, 10'd1, 10'd512,
               10'd77, 10'd300, 10'd999, 10'd5, 10'd640, 10'd256};
      for (int p = 0; p < PIXN; p++) peakMem[p] = '0;

      #2 res = 1'b1;
      #1 chkAllZero("reset");
      cyc();
      cyc();
      res = 1'b0;
      cyc();
      cyc();
      chk("no_auto_start", 32'(busy), 0);

      // normal frame, valid held high
      startFrame(1);
      feed(1'b0, 1'b1);
      readout(-1);

      // backpressure on pixel 2
      startFrame(2);
      feed(1'b0, 1'b1);
      readout(2);

      // gapped input
      startFrame(3);
      feed(1'b1, 1'b1);
      readout(-1);

      // abort during DRAIN
      startFrame(4);
      feed(1'b0, 1'b0);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("abort_drain_busy", 32'(busy), 0);
      chk("abort_drain_wr", 32'(hb_wr_en), 0);
      chk("abort_drain_peak", 32'(peak_valid), 0);
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk("abort_no_readout", 32'(peak_valid), 0);
      end

      // abort wins over start in IDLE
      start = 1'b1;
      abort = 1'b1;
      cyc();
      start = 1'b0;
      abort = 1'b0;
      chk("abort_start_busy", 32'(busy), 0);
      chk("abort_start_clr", 32'(hb_clr), 0);
      cyc();
      chk("abort_start_idle", 32'(busy), 0);

      // reset mid-ACQ, then restart three cycles later
      startFrame(5);
      for (int i = 0; i < 5; i++) begin
         tdc_valid = 1'b1;
         tdc_data  = samp[i];
         wq.push_back({PW'(i % PIXN), samp[i]});
         cyc();
      end
      #2 res = 1'b1;
      #1 chkAllZero("midacq_reset");
      tdc_valid = 1'b0;
      wq.delete();
      cyc();
      res = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("post_reset_idle", 32'(busy), 0);
         cyc();
      end
      startFrame(6);
      feed(1'b0, 1'b1);
      readout(-1);

      // no-hit codes at pixels 1 and 4
      samp[1] = NOHIT;
      samp[4] = NOHIT;
      startFrame(7);
      feed(1'b0, 1'b1);
      readout(-1);
`ifdef HIS_SEQ_NOHIT_FILTER_EN
      chk("nohit_cnt", 32'(nohit_cnt), 2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
